// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-requester SRAM arbiter: FSM encoding and default geometry.
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 4;
    localparam int unsigned DEF_DATA_WIDTH   = 8;
    localparam int unsigned DEF_READ_LATENCY = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // On a tie, favour whichever requester was not served last.
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (gnt != 2'b00) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Zero-initialises the SRAM after reset, then arbitrates two requesters onto it and
// returns read data through a tag pipeline matched to the SRAM read latency.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    init_done,
    output logic                    sram_we,
    output logic                    sram_oe,
    output logic [ADDR_WIDTH-1:0]   sram_address,
    output logic [DATA_WIDTH-1:0]   sram_data_in,
    input  logic [DATA_WIDTH-1:0]   sram_data_out
);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   init_addr_q;
    logic                    init_done_q;
    logic [1:0]              gnt;
    logic                    sel;
    logic                    issue_rd;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_id_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .req   (req_valid),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign init_done = init_done_q;
    assign sel       = gnt[1];
    assign issue_rd  = (gnt != 2'b00) && !req_we[sel];

    always_comb begin
        sram_we      = 1'b0;
        sram_address = '0;
        sram_data_in = '0;
        if (state_q == INIT) begin
            // Held off while reset is asserted so the SRAM sees no write until release.
            sram_we      = rst_n;
            sram_address = init_addr_q;
        end else if (gnt != 2'b00) begin
            sram_we      = req_we[sel];
            sram_address = sel ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
            sram_data_in = sel ? req_wdata[DATA_WIDTH +: DATA_WIDTH] : req_wdata[0 +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_addr_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    init_addr_q <= init_addr_q + 1'b1;
                    if (init_addr_q == '1) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // pipe_*_q[k] describes the read issued k+1 cycles ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            pipe_vld_q[0] <= issue_rd;
            pipe_id_q[0]  <= sel;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_id_q[k]  <= pipe_id_q[k-1];
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_oe_issue
            assign sram_oe = issue_rd;
        end else begin : g_oe_pipe
            assign sram_oe = pipe_vld_q[READ_LATENCY-2];
        end
    endgenerate

    assign rsp_valid = pipe_vld_q[READ_LATENCY-1] ?
                       (pipe_id_q[READ_LATENCY-1] ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = pipe_vld_q[READ_LATENCY-1] ? sram_data_out : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter with an SRAM model and a queue-based reference model.
module tb_sram_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int RL    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [1:0]    req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic          sram_we;
    logic          sram_oe;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_data_in;
    logic [DW-1:0] sram_data_out;

    sram_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .init_done     (init_done),
        .sram_we       (sram_we),
        .sram_oe       (sram_oe),
        .sram_address  (sram_address),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM wrapper model: write on the edge, read data appears RL cycles after the address.
    logic [DW-1:0] sram_mem [DEPTH];
    logic [DW-1:0] rd_pipe  [RL];
    always @(posedge clk) begin
        if (sram_we) sram_mem[sram_address] <= sram_data_in;
        rd_pipe[0] <= sram_mem[sram_address];
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign sram_data_out = rd_pipe[RL-1];

    // Reference model state.
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            last_gnt;
    int            init_cnt;
    int            cyc;
    int            n_checks;
    int            n_pass;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        else
            n_pass++;
    endtask

    task automatic step(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int            g;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [1:0]    ev;
        logic [DW-1:0] ed;
        logic          eoe;
        @(negedge clk);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        g = -1;
        if (init_cnt < DEPTH) begin
            check("init_ready", 32'(req_ready), 32'(0));
            check("init_done_lo", 32'(init_done), 32'(0));
            check("init_we", 32'(sram_we), 32'(1));
            check("init_addr", 32'(sram_address), 32'(init_cnt));
            check("init_din", 32'(sram_data_in), 32'(0));
        end else begin
            if (v == 2'b11) g = (last_gnt == 1) ? 0 : 1;
            else if (v[0])  g = 0;
            else if (v[1])  g = 1;
            a = (g == 1) ? a1 : a0;
            d = (g == 1) ? d1 : d0;
            check("ready", 32'(req_ready), (g < 0) ? 32'(0) : 32'(1) << g);
            check("init_done_hi", 32'(init_done), 32'(1));
            check("sram_we", 32'(sram_we), (g < 0) ? 32'(0) : 32'(we[g]));
            check("sram_addr", 32'(sram_address), (g < 0) ? 32'(0) : 32'(a));
            check("sram_din", 32'(sram_data_in), (g < 0) ? 32'(0) : 32'(d));
        end
        ev = 2'b00;
        ed = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            ev = 2'b01 << rsp_q[0].id;
            ed = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
        if (g >= 0) begin
            last_gnt = g;
            if (we[g]) ref_mem[a] = d;
            else       rsp_q.push_back('{due: cyc + RL, id: g, data: ref_mem[a]});
        end
        eoe = 1'b0;
        foreach (rsp_q[i]) if (rsp_q[i].due == cyc + RL - 1) eoe = 1'b1;
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        check("rsp_rdata", 32'(rsp_rdata), 32'(ed));
        check("sram_oe", 32'(sram_oe), 32'(eoe));
        if (init_cnt < DEPTH) init_cnt++;
        cyc++;
    endtask

    // Asserts reset mid-cycle, checks the reset outputs, releases just after the next edge.
    task automatic do_reset();
        req_valid = 2'b00;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_init_done", 32'(init_done), 32'(0));
        check("rst_sram_we", 32'(sram_we), 32'(0));
        check("rst_sram_oe", 32'(sram_oe), 32'(0));
        check("rst_sram_addr", 32'(sram_address), 32'(0));
        check("rst_sram_din", 32'(sram_data_in), 32'(0));
        rsp_q.delete();
        init_cnt = 0;
        last_gnt = 1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        #3;
        do_reset();

        // Requester 1 waits through INIT and is taken on the first RUN cycle.
        repeat (DEPTH + 1) step(2'b10, 2'b00, 4'd0, 4'd5, 8'h00, 8'h00);

        // Every address reads back zero.
        for (int i = 0; i < DEPTH; i++) step(2'b01, 2'b00, 4'(i), 4'd0, 8'h00, 8'h00);
        repeat (RL) step(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);

        // Write then immediately read the same address.
        step(2'b01, 2'b01, 4'd3, 4'd0, 8'h5A, 8'h00);
        step(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
        step(2'b10, 2'b10, 4'd0, 4'd7, 8'h00, 8'hC3);
        repeat (RL) step(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);

        // Both requesters reading continuously.
        for (int i = 0; i < 8; i++) step(2'b11, 2'b00, 4'd3, 4'd7, 8'h00, 8'h00);

        // Requester 1 alone, back-to-back reads.
        for (int i = 0; i < 4; i++) step(2'b10, 2'b00, 4'd0, 4'(i), 8'h00, 8'h00);
        repeat (RL) step(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);

        for (int i = 0; i < 400; i++)
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, DEPTH - 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        // Reset with two reads in flight: none may respond, INIT restarts at address 0.
        step(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
        step(2'b10, 2'b00, 4'd0, 4'd7, 8'h00, 8'h00);
        do_reset();
        repeat (DEPTH + 1) step(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);

        for (int i = 0; i < 100; i++)
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, DEPTH - 1)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        repeat (RL + 1) step(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
        check("drain", 32'(rsp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
